// File: rtl/adc_display_pkg.sv
// Shared types, seven-segment patterns and constant helpers for the ADC display block.
package adc_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } conv_state_e;

   // Active-low segment patterns, bit order g..a
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Ceiling log2, never less than 1 so single-entry ranges still get a bit
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/adc_display_bin2bcd_seq.sv
// Sequential double-dabble converter: LOAD captures bin, DW shift steps, one DONE cycle.
module bin2bcd_seq
   import adc_display_pkg::*;
#(
   parameter int unsigned DW   = 12,
   parameter int unsigned NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DW-1:0]     bin,
   output logic              busy,
   output logic              done,
   output logic              load_c,
   output logic [4*NDIG-1:0] bcd
);
   localparam int unsigned BW   = 4 * NDIG;
   localparam int unsigned CNTW = clog2(DW);

   conv_state_e          state_q, state_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic [BW+DW-1:0]     sr_q, sr_d, adj;
   logic                 busy_q, busy_d, done_q, done_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      adj     = sr_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: begin
            sr_d    = {BW'(0), bin};
            cnt_d   = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            // add-3 correction on every BCD nibble before the shift
            for (int i = 0; i < NDIG; i++) begin
               if (adj[DW+4*i +: 4] >= 4'd5) adj[DW+4*i +: 4] = adj[DW+4*i +: 4] + 4'd3;
            end
            sr_d  = {adj[BW+DW-2:0], 1'b0};
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(DW - 1)) state_d = ST_DONE;
         end
         ST_DONE: state_d = start ? ST_LOAD : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign load_c = (state_q == ST_LOAD);
   assign bcd    = sr_q[DW +: BW];

endmodule

// File: rtl/adc_display.sv
// Multi-channel ADC sample display: channel select/auto-cycle, BCD conversion, 7-seg scan.
module adc_display
   import adc_display_pkg::*;
#(
   parameter int unsigned NCH      = 2,
   parameter int unsigned DW       = 12,
   parameter int unsigned NDIG     = 4,
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DWELL    = 50000000
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [NCH*DW-1:0]      data,
   input  logic [NCH-1:0]         data_valid,
   input  logic                   auto_mode,
   input  logic [clog2(NCH)-1:0]  ch_sel,
   output logic [NDIG-1:0]        an,
   output logic [6:0]             seg,
   output logic                   dp,
   output logic                   busy
);
   localparam int unsigned CW   = clog2(NCH);
   localparam int unsigned DGW  = clog2(NDIG);
   localparam int unsigned SCW  = clog2(SCAN_DIV);
   localparam int unsigned DWW  = clog2(DWELL);
   localparam int unsigned BW   = 4 * NDIG;
   localparam int unsigned MAXV = pow10(NDIG) - 1;

   logic [DW-1:0]   sample_q [NCH];
   logic [DW-1:0]   sample_d [NCH];
   logic [CW-1:0]   sel_q, sel_d, auto_idx_q, auto_idx_d, prev_idx_q, prev_idx_d;
   logic [CW-1:0]   snap_ch_q, snap_ch_d, disp_ch_q, disp_ch_d, disp_idx_c;
   logic [DWW-1:0]  dwell_q, dwell_d;
   logic [SCW-1:0]  scan_q, scan_d;
   logic [DGW-1:0]  dig_q, dig_d;
   logic [BW-1:0]   disp_dig_q, disp_dig_d;
   logic [NDIG-1:0] an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic [3:0]      digs [NDIG];
   logic [NDIG-1:0] blank_c;
   logic [DW-1:0]   cur_sample_c;
   logic            auto_q, auto_d, first_q, first_d, pending_q, pending_d;
   logic            snap_ovf_q, snap_ovf_d, disp_ovf_q, disp_ovf_d, dp_q, dp_d;
   logic            trig_c, start_c, seen;
   logic            conv_busy, conv_done, conv_load_c;
   logic [BW-1:0]   conv_bcd;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sample_q   <= '{default: '0};
         sel_q      <= '0;
         auto_idx_q <= '0;
         prev_idx_q <= '0;
         snap_ch_q  <= '0;
         disp_ch_q  <= '0;
         dwell_q    <= '0;
         scan_q     <= '0;
         dig_q      <= '0;
         disp_dig_q <= '0;
         an_q       <= ~NDIG'(1);
         seg_q      <= SEG_0;
         dp_q       <= 1'b0;
         auto_q     <= 1'b0;
         first_q    <= 1'b1;
         pending_q  <= 1'b0;
         snap_ovf_q <= 1'b0;
         disp_ovf_q <= 1'b0;
      end else begin
         sample_q   <= sample_d;
         sel_q      <= sel_d;
         auto_idx_q <= auto_idx_d;
         prev_idx_q <= prev_idx_d;
         snap_ch_q  <= snap_ch_d;
         disp_ch_q  <= disp_ch_d;
         dwell_q    <= dwell_d;
         scan_q     <= scan_d;
         dig_q      <= dig_d;
         disp_dig_q <= disp_dig_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         auto_q     <= auto_d;
         first_q    <= first_d;
         pending_q  <= pending_d;
         snap_ovf_q <= snap_ovf_d;
         disp_ovf_q <= disp_ovf_d;
      end
   end

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         sample_d[k] = data_valid[k] ? data[k*DW +: DW] : sample_q[k];
      end
      sel_d      = (32'(ch_sel) >= NCH) ? '0 : ch_sel;
      auto_d     = auto_mode;
      auto_idx_d = auto_idx_q;
      dwell_d    = '0;
      // entering auto mode restarts the dwell from the manually selected channel
      if (auto_mode && !auto_q) begin
         auto_idx_d = sel_d;
      end else if (auto_mode) begin
         if (dwell_q == DWW'(DWELL - 1)) begin
            auto_idx_d = (32'(auto_idx_q) == NCH - 1) ? '0 : auto_idx_q + CW'(1);
         end else begin
            dwell_d = dwell_q + DWW'(1);
         end
      end

      disp_idx_c   = auto_q ? auto_idx_q : sel_q;
      cur_sample_c = sample_q[disp_idx_c];
      prev_idx_d   = disp_idx_c;
      first_d      = 1'b0;
      trig_c       = !first_q && (data_valid[disp_idx_c] || (disp_idx_c != prev_idx_q));
      start_c      = (!conv_busy || conv_done) && (trig_c || pending_q);
      pending_d    = pending_q;
      if (start_c)                 pending_d = 1'b0;
      else if (trig_c && conv_busy) pending_d = 1'b1;

      snap_ch_d  = snap_ch_q;
      snap_ovf_d = snap_ovf_q;
      if (conv_load_c) begin
         snap_ch_d  = disp_idx_c;
         snap_ovf_d = (32'(cur_sample_c) > MAXV);
      end
      disp_dig_d = disp_dig_q;
      disp_ch_d  = disp_ch_q;
      disp_ovf_d = disp_ovf_q;
      if (conv_done) begin
         disp_dig_d = conv_bcd;
         disp_ch_d  = snap_ch_q;
         disp_ovf_d = snap_ovf_q;
      end

      scan_d = scan_q + SCW'(1);
      dig_d  = dig_q;
      if (scan_q == SCW'(SCAN_DIV - 1)) begin
         scan_d = '0;
         dig_d  = (32'(dig_q) == NDIG - 1) ? '0 : dig_q + DGW'(1);
      end

      // leading-zero blanking scans from the most significant digit down
      seen = 1'b0;
      for (int j = 0; j < NDIG; j++) begin
         digs[j] = disp_dig_q[4*j +: 4];
      end
      for (int j = 0; j < NDIG; j++) begin
         seen = seen | (digs[NDIG-1-j] != 4'd0);
         blank_c[NDIG-1-j] = !seen && (j != NDIG - 1);
      end

      an_d = ~(NDIG'(1) << dig_q);
      if (disp_ovf_q)          seg_d = SEG_DASH;
      else if (blank_c[dig_q]) seg_d = SEG_BLANK;
      else                     seg_d = seg_decode(digs[dig_q]);
      dp_d = !(32'(dig_q) == (32'(disp_ch_q) % NDIG));
   end

   bin2bcd_seq #(.DW(DW), .NDIG(NDIG)) u_conv (
      .clk    (CLK),
      .rst_n  (RST_N),
      .start  (start_c),
      .bin    (cur_sample_c),
      .busy   (conv_busy),
      .done   (conv_done),
      .load_c (conv_load_c),
      .bcd    (conv_bcd)
   );

   assign an   = an_q;
   assign seg  = seg_q;
   assign dp   = dp_q;
   assign busy = conv_busy;

endmodule

// File: tb/tb_adc_display.sv
// Directed bench for adc_display: a 3-channel 12-bit instance and a 16-bit instance.
module tb_adc_display;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [35:0] data_a;
   logic [2:0]  dv_a;
   logic        auto_a;
   logic [1:0]  ch_a;
   logic [3:0]  an_a;
   logic [6:0]  seg_a;
   logic        dp_a, busy_a;
   logic [31:0] data_b;
   logic [1:0]  dv_b;
   logic        auto_b;
   logic [0:0]  ch_b;
   logic [3:0]  an_b;
   logic [6:0]  seg_b;
   logic        dp_b, busy_b;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] val;
      logic [27:0] segs;
      logic [3:0]  dps;
   } vec_t;

   vec_t va [7];
   vec_t vb [3];

   adc_display #(.NCH(3), .DW(12), .NDIG(4), .SCAN_DIV(4), .DWELL(100)) u_a (
      .CLK(clk), .RST_N(rst_n), .data(data_a), .data_valid(dv_a), .auto_mode(auto_a),
      .ch_sel(ch_a), .an(an_a), .seg(seg_a), .dp(dp_a), .busy(busy_a)
   );

   adc_display #(.NCH(2), .DW(16), .NDIG(4), .SCAN_DIV(4), .DWELL(100)) u_b (
      .CLK(clk), .RST_N(rst_n), .data(data_b), .data_valid(dv_b), .auto_mode(auto_b),
      .ch_sel(ch_b), .an(an_b), .seg(seg_b), .dp(dp_b), .busy(busy_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Observe one full scan, collecting seg/dp per digit; an must be one-hot-low throughout
   task automatic read_disp(input int sel, output logic [27:0] segs, output logic [3:0] dps,
                            output int an_ok);
      logic [3:0] seen, a;
      an_ok = 1;
      seen  = 4'h0;
      segs  = '1;
      dps   = '1;
      repeat (40) begin
         @(negedge clk);
         a = (sel != 0) ? an_b : an_a;
         if ((a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111)) begin
            for (int j = 0; j < 4; j++) begin
               if (a == ~(4'b0001 << j)) begin
                  segs[j*7 +: 7] = (sel != 0) ? seg_b : seg_a;
                  dps[j]         = (sel != 0) ? dp_b : dp_a;
                  seen[j]        = 1'b1;
               end
            end
         end else begin
            an_ok = 0;
         end
      end
      if (seen != 4'hF) an_ok = 0;
   endtask

   task automatic chk_disp(input string tag, input int sel, input logic [27:0] exp_segs,
                           input logic [3:0] exp_dps);
      logic [27:0] segs;
      logic [3:0]  dps;
      int          an_ok;
      read_disp(sel, segs, dps, an_ok);
      chk({tag, " an one-hot"}, an_ok, 1);
      for (int j = 0; j < 4; j++)
         chk($sformatf("%s dig%0d seg", tag, j), int'(segs[j*7 +: 7]), int'(exp_segs[j*7 +: 7]));
      chk({tag, " dp"}, int'(dps), int'(exp_dps));
   endtask

   task automatic run_vec(input int sel, input vec_t v, input int exp_busy, input string tag);
      int k, n;
      k = (v.ch >= 2'd3) ? 0 : int'(v.ch);
      if (sel == 0) begin
         ch_a = v.ch;
         repeat (40) @(negedge clk);
      end
      @(negedge clk);
      if (sel == 0) begin
         data_a = '0;
         data_a[k*12 +: 12] = v.val[11:0];
         dv_a = 3'b001 << k;
      end else begin
         data_b = {16'h0, v.val};
         dv_b   = 2'b01;
      end
      @(negedge clk);
      dv_a = '0;
      dv_b = '0;
      n = 0;
      for (int i = 0; i < 200 && ((sel != 0) ? busy_b : busy_a); i++) begin
         n++;
         @(negedge clk);
      end
      chk({tag, " busy cycles"}, n, exp_busy);
      repeat (3) @(negedge clk);
      chk_disp(tag, sel, v.segs, v.dps);
   endtask

   initial begin
      int n, t, t_prev, c0;
      logic [3:0] exp_dp [3];

      va[0] = '{2'd0, 16'h0FFF, {7'h19, 7'h40, 7'h10, 7'h12}, 4'b1110};
      va[1] = '{2'd1, 16'h0005, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1101};
      va[2] = '{2'd3, 16'h007B, {7'h7F, 7'h79, 7'h24, 7'h30}, 4'b1110};
      va[3] = '{2'd2, 16'h03E8, {7'h79, 7'h40, 7'h40, 7'h40}, 4'b1011};
      va[4] = '{2'd1, 16'h0050, {7'h7F, 7'h7F, 7'h00, 7'h40}, 4'b1101};
      va[5] = '{2'd2, 16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011};
      va[6] = '{2'd0, 16'h0999, {7'h24, 7'h19, 7'h12, 7'h78}, 4'b1110};
      vb[0] = '{2'd0, 16'h3039, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1110};
      vb[1] = '{2'd0, 16'h270F, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b1110};
      vb[2] = '{2'd0, 16'h2710, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1110};

      rst_n = 1'b0;
      data_a = '0; dv_a = 3'b001; auto_a = 1'b0; ch_a = '0;
      data_b = '0; dv_b = '0;     auto_b = 1'b0; ch_b = '0;
      repeat (3) @(negedge clk);
      chk("reset an", int'(an_a), 4'b1110);
      chk("reset seg", int'(seg_a), 7'h40);
      chk("reset dp", int'(dp_a), 0);
      chk("reset busy", int'(busy_a), 0);

      // valid still high on the first cycle out of reset must not start a conversion
      rst_n = 1'b1;
      @(negedge clk);
      dv_a = '0;
      n = 0;
      repeat (10) begin
         if (busy_a) n++;
         @(negedge clk);
      end
      chk("no trigger after reset", n, 0);

      for (int i = 0; i < 7; i++) run_vec(0, va[i], 14, $sformatf("a%0d", i));
      for (int i = 0; i < 3; i++) run_vec(1, vb[i], 18, $sformatf("b%0d", i));

      // several triggers during one conversion merge into exactly one follow-up
      ch_a = 2'd0;
      repeat (40) @(negedge clk);
      data_a = '0; data_a[11:0] = 12'h111; dv_a = 3'b001;
      @(negedge clk);
      dv_a = '0;
      n = 0;
      for (int i = 0; i < 200 && busy_a; i++) begin
         n++;
         dv_a = '0;
         if (n == 3) begin data_a[11:0] = 12'h222; dv_a = 3'b001; end
         if (n == 6) begin data_a[11:0] = 12'h333; dv_a = 3'b001; end
         if (n == 9) begin data_a[11:0] = 12'h456; dv_a = 3'b001; end
         @(negedge clk);
      end
      dv_a = '0;
      chk("merge busy cycles", n, 28);
      repeat (3) @(negedge clk);
      chk_disp("merge", 0, {7'h79, 7'h79, 7'h79, 7'h40}, 4'b1110);

      // reset in the middle of SHIFT aborts the conversion
      @(negedge clk);
      data_a[11:0] = 12'h123; dv_a = 3'b001;
      @(negedge clk);
      dv_a = '0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort busy", int'(busy_a), 0);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk_disp("abort", 0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110);

      // auto mode cycles 0 -> 1 -> 2 -> 0 every 100 cycles
      exp_dp[0] = 4'b1101; exp_dp[1] = 4'b1011; exp_dp[2] = 4'b1110;
      @(negedge clk);
      ch_a   = 2'd0;
      auto_a = 1'b1;
      c0     = cyc;
      t_prev = c0;
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 250 && !busy_a; i++) @(negedge clk);
         chk($sformatf("auto%0d busy", s), int'(busy_a), 1);
         t = cyc;
         chk($sformatf("auto%0d interval", s), t - t_prev, (s == 0) ? 102 : 100);
         t_prev = t;
         for (int i = 0; i < 50 && busy_a; i++) @(negedge clk);
         chk_disp($sformatf("auto%0d", s), 0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, exp_dp[s]);
      end
      auto_a = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
